// File: rtl/reg_stream_packer_pkg.sv
// Shared constants, types and helpers for the byte-to-word stream packer.
package reg_stream_packer_pkg;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef logic [$clog2(LANES)-1:0] lane_t;
  typedef logic [BYTE_W-1:0]        byte_t;
  typedef logic [WORD_W-1:0]        word_t;

  // Drop a byte into its little-endian lane of a partially built word.
  function automatic word_t place_byte(word_t w, byte_t b, lane_t lane);
    return w | (word_t'(b) << (BYTE_W * int'(lane)));
  endfunction

endpackage

// File: rtl/reg_stream_packer_if.sv
// Byte input, word output and status bundle of the stream packer.
interface reg_stream_packer_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 16
);
  import reg_stream_packer_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  byte_t                 din;
  logic                  din_vld;
  logic                  flush;
  word_t                 dout_data;
  logic                  dout_vld;
  logic                  dout_rd;
  logic [LVL_W-1:0]      level;
  logic [DROP_CNT_W-1:0] drop_cnt;

  // Producer/consumer side (testbench or surrounding logic).
  modport master (
    output din, din_vld, flush, dout_rd,
    input  dout_data, dout_vld, level, drop_cnt
  );

  // Packer side.
  modport slave (
    input  din, din_vld, flush, dout_rd,
    output dout_data, dout_vld, level, drop_cnt
  );

endinterface

// File: rtl/reg_stream_packer_fifo.sv
// First-word-fall-through word FIFO; occupancy count separates full from empty.
module reg_stream_packer_fifo
  import reg_stream_packer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  word_t            data_in,
  output logic             full,
  input  logic             pop,
  output word_t            data_out,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  word_t             r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full  = (r_level == LVL_W'(DEPTH));
  assign empty = (r_level == '0);

  // A full FIFO still takes a word when the head leaves in the same edge.
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  assign data_out = empty ? '0 : r_mem[r_rd_ptr];
  assign level    = r_level;

  // Storage write port.
  // NOTE: the word array has no reset; stale entries are unreachable because
  // data_out is masked while empty and only written slots are ever read.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop_ok);
    end
  end

endmodule

// File: rtl/reg_stream_packer.sv
// Packs a qualified byte stream into little-endian 32-bit words, buffers them
// in a FWFT FIFO and counts words lost to overflow.
module reg_stream_packer
  import reg_stream_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  reg_stream_packer_if.slave bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  lane_t                 r_lane;
  word_t                 r_asm;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  word_t                 w_word;
  logic                  w_last;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;

  // The byte arriving this cycle is always folded in before any push, so a
  // flush that coincides with the last lane still yields a single word.
  assign w_word = bus.din_vld ? place_byte(r_asm, bus.din, r_lane) : r_asm;
  assign w_last = bus.din_vld && (r_lane == lane_t'(LANES - 1));
  assign w_push = w_last || (bus.flush && (bus.din_vld || (r_lane != '0)));
  assign w_drop = w_push && w_full && !bus.dout_rd;

  // Lane counter and assembly register; both clear whenever a word leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane <= '0;
      r_asm  <= '0;
    end else if (w_push) begin
      r_lane <= '0;
      r_asm  <= '0;
    end else if (bus.din_vld) begin
      r_lane <= r_lane + 1'b1;
      r_asm  <= w_word;
    end
  end

  // Saturating count of words discarded because the FIFO was full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  reg_stream_packer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .data_in  (w_word),
    .full     (w_full),
    .pop      (bus.dout_rd),
    .data_out (bus.dout_data),
    .empty    (w_empty),
    .level    (bus.level)
  );

  assign bus.dout_vld = !w_empty;
  assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_reg_stream_packer.sv
// Self-checking bench: directed scenarios plus a randomized run, checked
// against a queue-based model of the byte/word stream.
module tb_reg_stream_packer;
  import reg_stream_packer_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  reg_stream_packer_if #(.FIFO_DEPTH(DEPTH), .DROP_CNT_W(16)) bus  ();
  reg_stream_packer_if #(.FIFO_DEPTH(DEPTH), .DROP_CNT_W(2))  bus2 ();

  reg_stream_packer #(.FIFO_DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  reg_stream_packer #(.FIFO_DEPTH(DEPTH), .DROP_CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: bytes of the word being built, delivered words, drops.
  byte_t m_part [$];
  word_t m_q    [$];
  int    m_drops;

  function automatic word_t exp_head();
    return (m_q.size() != 0) ? m_q[0] : 32'h0;
  endfunction

  function automatic int sat(int v, int max);
    return (v > max) ? max : v;
  endfunction

  function automatic word_t mk_word(int b0);
    return {8'(b0 + 3), 8'(b0 + 2), 8'(b0 + 1), 8'(b0)};
  endfunction

  task automatic model_update(input logic r, input logic v, input byte_t d,
                              input logic f, input logic rd);
    word_t w;
    bit    do_pop;
    bit    was_full;
    bit    do_push;
    if (r) begin
      m_part.delete();
      m_q.delete();
      m_drops = 0;
    end else begin
      do_pop   = rd && (m_q.size() != 0);
      was_full = (m_q.size() == DEPTH);
      do_push  = 1'b0;
      w        = '0;
      if (v) m_part.push_back(d);
      if (m_part.size() == LANES || (f && m_part.size() != 0)) begin
        for (int i = 0; i < m_part.size(); i++) w = w + (word_t'(m_part[i]) << (8 * i));
        m_part.delete();
        do_push = 1'b1;
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        if (was_full && !do_pop) m_drops++;
        else m_q.push_back(w);
      end
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, settle at negedge.
  task automatic step(input logic r, input logic v, input byte_t d,
                      input logic f, input logic rd);
    rst          = r;
    bus.din      = d;    bus2.din     = d;
    bus.din_vld  = v;    bus2.din_vld = v;
    bus.flush    = f;    bus2.flush   = f;
    bus.dout_rd  = rd;   bus2.dout_rd = rd;
    @(posedge clk);
    model_update(r, v, d, f, rd);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    // Busy inputs during reset must be ignored.
    step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'hC3, 1'b0, 1'b1);
    n_vec++; if (bus.dout_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", bus.dout_vld); end
    n_vec++; if (bus.dout_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 00000000", bus.dout_data); end
    n_vec++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    n_vec++; if (bus.drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", bus.drop_cnt); end
    // Lane counter cleared: four bytes after reset form exactly one word.
    step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    n_vec++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL reset_lane: got level %0d want 0", bus.level); end
    step(1'b0, 1'b1, 8'h04, 1'b0, 1'b0);
    n_vec++; if (bus.dout_data !== 32'h04030201) begin n_err++; $display("FAIL reset_word: got %h want 04030201", bus.dout_data); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      n_vec++; if (bus.dout_vld !== 1'b0) begin n_err++; $display("FAIL basic_early_vld: byte %0d got %b want 0", i, bus.dout_vld); end
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b1);
    end
    n_vec++; if (bus.dout_vld !== 1'b1) begin n_err++; $display("FAIL basic_vld: got %b want 1", bus.dout_vld); end
    n_vec++; if (bus.dout_data !== 32'h04030201) begin n_err++; $display("FAIL basic_data: got %h want 04030201", bus.dout_data); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    n_vec++; if (bus.dout_vld !== 1'b0) begin n_err++; $display("FAIL basic_one_cycle: got %b want 0", bus.dout_vld); end
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'hBB, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    n_vec++; if (bus.dout_vld !== 1'b1) begin n_err++; $display("FAIL flush_vld: got %b want 1", bus.dout_vld); end
    n_vec++; if (bus.dout_data !== 32'h0000BBAA) begin n_err++; $display("FAIL flush_data: got %h want 0000bbaa", bus.dout_data); end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h11 + i), 1'b0, 1'b1);
    n_vec++; if (bus.dout_data !== 32'h14131211) begin n_err++; $display("FAIL flush_next: got %h want 14131211", bus.dout_data); end
    n_vec++; if (bus.level !== 3'd1) begin n_err++; $display("FAIL flush_next_level: got %0d want 1", bus.level); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    // Flush with nothing assembled is a no-op.
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_vec++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL flush_idle: got level %0d want 0", bus.level); end
    // Flush together with the lane-3 byte yields a single word.
    step(1'b0, 1'b1, 8'h21, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h23, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h24, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    n_vec++; if (bus.level !== 3'd1) begin n_err++; $display("FAIL flush_lane3_level: got %0d want 1", bus.level); end
    n_vec++; if (bus.dout_data !== 32'h24232221) begin n_err++; $display("FAIL flush_lane3_data: got %h want 24232221", bus.dout_data); end
    // Flush together with a lane-0 byte emits a one-byte word.
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    n_vec++; if (bus.dout_data !== 32'h00000077) begin n_err++; $display("FAIL flush_lane0_data: got %h want 00000077", bus.dout_data); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 8'(k + 1), 1'b0, 1'b0);
    n_vec++; if (bus.level !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d want 4", bus.level); end
    n_vec++; if (bus.drop_cnt !== 16'd1) begin n_err++; $display("FAIL ovf_drop: got %0d want 1", bus.drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (bus.dout_data !== mk_word(4 * i + 1)) begin n_err++; $display("FAIL ovf_drain%0d: got %h want %h", i, bus.dout_data, mk_word(4 * i + 1)); end
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    n_vec++; if (bus.dout_vld !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", bus.dout_vld); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int k = 0; k < 19; k++) step(1'b0, 1'b1, 8'(k + 1), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'd20, 1'b0, 1'b1);
    n_vec++; if (bus.level !== 3'd4) begin n_err++; $display("FAIL fullpop_level: got %0d want 4", bus.level); end
    n_vec++; if (bus.drop_cnt !== 16'd0) begin n_err++; $display("FAIL fullpop_drop: got %0d want 0", bus.drop_cnt); end
    n_vec++; if (bus.dout_data !== mk_word(5)) begin n_err++; $display("FAIL fullpop_head: got %h want %h", bus.dout_data, mk_word(5)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
    n_vec++; if (bus.level !== 3'd2) begin n_err++; $display("FAIL rstmid_pre_level: got %0d want 2", bus.level); end
    step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
    n_vec++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL rstmid_level: got %0d want 0", bus.level); end
    n_vec++; if (bus.dout_vld !== 1'b0) begin n_err++; $display("FAIL rstmid_vld: got %b want 0", bus.dout_vld); end
    n_vec++; if (bus.drop_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_drop: got %0d want 0", bus.drop_cnt); end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'(8'h61 + k), 1'b0, 1'b0);
    n_vec++; if (bus.dout_data !== 32'h64636261) begin n_err++; $display("FAIL rstmid_fresh: got %h want 64636261", bus.dout_data); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 36; k++) step(1'b0, 1'b1, 8'(k), 1'b0, 1'b0);
    n_vec++; if (bus2.drop_cnt !== 2'h3) begin n_err++; $display("FAIL sat_drop2: got %0d want 3", bus2.drop_cnt); end
    n_vec++; if (bus.drop_cnt !== 16'd5) begin n_err++; $display("FAIL sat_drop16: got %0d want 5", bus.drop_cnt); end
  endtask

  task automatic test_random();
    logic  r;
    logic  v;
    logic  f;
    logic  rd;
    byte_t d;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      n_vec++; if (bus.dout_vld !== (m_q.size() != 0)) begin n_err++; $display("FAIL rand_vld@%0d: got %b want %b", c, bus.dout_vld, (m_q.size() != 0)); end
      n_vec++; if (bus.dout_data !== exp_head()) begin n_err++; $display("FAIL rand_data@%0d: got %h want %h", c, bus.dout_data, exp_head()); end
      n_vec++; if (bus.level !== 3'(m_q.size())) begin n_err++; $display("FAIL rand_level@%0d: got %0d want %0d", c, bus.level, m_q.size()); end
      n_vec++; if (bus.drop_cnt !== 16'(sat(m_drops, 65535))) begin n_err++; $display("FAIL rand_drop@%0d: got %0d want %0d", c, bus.drop_cnt, m_drops); end
      n_vec++; if (bus2.drop_cnt !== 2'(sat(m_drops, 3))) begin n_err++; $display("FAIL rand_drop_sat@%0d: got %0d want %0d", c, bus2.drop_cnt, sat(m_drops, 3)); end
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 9) < 7);
      f  = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 3 : 7));
      d  = 8'($urandom);
      step(r, v, d, f, rd);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_drops = 0;
    rst          = 1'b1;
    bus.din      = '0;   bus2.din     = '0;
    bus.din_vld  = 1'b0; bus2.din_vld = 1'b0;
    bus.flush    = 1'b0; bus2.flush   = 1'b0;
    bus.dout_rd  = 1'b0; bus2.dout_rd = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_flush();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_stream_packer.md
REG_STREAM_PACKER -- requirements
Module: reg_stream_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL be the number of 32-bit words buffered (power of two, 2..16).
REQ-002 Parameter DROP_CNT_W, default 16, SHALL be the width of the drop counter.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  SHALL be the only clock; all state changes on its rising edge.
REQ-005 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-006 din  in  8  SHALL be the per-cycle byte from the upstream register chain.
REQ-007 din_vld  in  1  SHALL qualify din; there is no backpressure to upstream.
REQ-008 flush  in  1  SHALL be a single-cycle request to emit a partially assembled word.
REQ-009 dout_data  out  32  SHALL be the packed word at the FIFO head.
REQ-010 dout_vld  out  1  SHALL indicate that dout_data holds a valid word.
REQ-011 dout_rd  in  1  SHALL be consumer ready; transfer occurs when dout_vld and dout_rd are both 1.
REQ-012 level  out  clog2(FIFO_DEPTH)+1  SHALL be the current FIFO occupancy.
REQ-013 drop_cnt  out  DROP_CNT_W  SHALL count words lost due to a full FIFO.

Function
REQ-014 Bytes with din_vld=1 SHALL be assembled little-endian: first byte -> bits [7:0], fourth byte -> bits [31:24].
REQ-015 A 2-bit lane counter SHALL advance 0->1->2->3->0 on each accepted byte and hold otherwise.
REQ-016 On acceptance of the byte at lane 3, the completed word SHALL be pushed to the FIFO in the same edge.
REQ-017 flush=1 with lane counter >0 SHALL push the partial word with unfilled lanes zero and reset the lane counter to 0.
REQ-018 flush=1 with lane counter 0 and no byte accepted that cycle SHALL have no effect.
REQ-019 flush and din_vld together SHALL include that byte first, then push (a byte at lane 3 yields one push, not two).
REQ-020 Latency: a word pushed into an empty FIFO at edge N SHALL appear with dout_vld=1 in the cycle after edge N.
REQ-021 The FIFO SHALL be first-word-fall-through; dout_data SHALL be stable while dout_vld=1 and dout_rd=0.
REQ-022 Push while full and dout_rd=0 SHALL drop the word, leave the FIFO unchanged, and increment drop_cnt.
REQ-023 Push while full and dout_rd=1 in the same cycle SHALL accept the word; level stays FIFO_DEPTH.
REQ-024 Simultaneous push and pop at any non-full level SHALL leave level unchanged.
REQ-025 drop_cnt SHALL saturate at all-ones and never wrap.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by level.

Reset
REQ-027 While rst=1: dout_vld=0, dout_data=0, level=0, drop_cnt=0, lane counter=0, and the assembly register is cleared.
REQ-028 rst asserted mid-word SHALL discard the partial word and all buffered words without incrementing drop_cnt.
REQ-029 din_vld, flush and dout_rd SHALL be ignored in any cycle where rst=1.

Structure
REQ-030 A shared package SHALL hold LANES=4, BYTE_W=8, WORD_W=32 and the lane-index type.
REQ-031 The FIFO SHALL be a separate sub-module, reg_stream_packer_fifo, with push/data_in/full and pop/data_out/empty/level.
REQ-032 Byte assembly, flush and drop counting SHALL reside in reg_stream_packer.

Verification
REQ-033 Reset, then bytes 0x01,0x02,0x03,0x04 on consecutive cycles with dout_rd=1 -> dout_data=0x04030201, dout_vld for exactly one cycle, one cycle after the 4th byte.
REQ-034 Bytes 0xAA,0xBB then flush -> dout_data=0x0000BBAA; next 4 bytes 0x11..0x14 -> 0x14131211.
REQ-035 dout_rd=0, 20 contiguous bytes -> level=4, drop_cnt=1; drain -> the first four words in order.
REQ-036 FIFO full, 4th byte of a word arrives with dout_rd=1 -> no drop, level remains 4, head advances.
REQ-037 rst pulsed after 2 bytes with FIFO level 2 -> level=0, dout_vld=0, drop_cnt=0; next 4 bytes form a fresh word.
REQ-038 drop_cnt forced to saturate (DROP_CNT_W=2, 5 drops) -> drop_cnt stays 0x3.
